// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE scatter sequencer.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN
  } state_t;

  // Requested load length limited to the number of demux slots.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/pe_scatter_cnt.sv
// Saturating word counter; its value doubles as the demux slot pointer.
module pe_scatter_cnt #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [CW-1:0] lim,
  output logic [CW-1:0] cnt,
  output logic          term,
  output logic          term_nxt
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !term) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign term     = (cnt == lim);
  // High when one more increment reaches the limit.
  assign term_nxt = ((cnt + CW'(1)) == lim);

endmodule

// File: rtl/pe_scatter_seq.sv
// Sequencer feeding the PE 1-to-N demux: scatters a valid/ready word stream
// over slots 0..len_eff-1 and pulses done when the load finishes or aborts.
module pe_scatter_seq
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 33,
  parameter int SEL_WIDTH  = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_WIDTH:0]    len,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] dmx_data,
  output logic [SEL_WIDTH-1:0]  dmx_sel,
  output logic                  dmx_en,
  output logic                  busy,
  output logic                  done,
  output logic [SEL_WIDTH:0]    count
);

  localparam int CW = SEL_WIDTH + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] len_q;
  logic [CW-1:0] len_eff;
  logic          accept;
  logic          cnt_clr;
  logic          term;
  logic          term_nxt;

  assign len_eff = CW'(clamp_len(32'(len), DATA_DEPTH));
  assign accept  = in_valid & in_ready;
  assign busy    = (state == LOAD);

  pe_scatter_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (accept),
    .lim      (len_q),
    .cnt      (count),
    .term     (term),
    .term_nxt (term_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        len_q <= len_eff;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          state_nxt = (len_eff == '0) ? FIN : LOAD;
        end
      end
      LOAD: begin
        // Abort masks the handshake so a word presented with it is dropped.
        in_ready = !term && !abort;
        if (abort) begin
          state_nxt = FIN;
        end else if (accept && term_nxt) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The counter value before the increment is the slot for this word; it
  // stays below len_q <= DATA_DEPTH whenever a word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmx_data <= '0;
      dmx_sel  <= '0;
      dmx_en   <= 1'b0;
      done     <= 1'b0;
    end else begin
      dmx_en <= accept;
      done   <= (state == FIN);
      if (accept) begin
        dmx_data <= in_data;
        dmx_sel  <= count[SEL_WIDTH-1:0];
      end
    end
  end

endmodule
